// File: rtl/controle_aspirador.sv
// controle_aspirador: robot vacuum motion sequencer with input synchronisers, timed maneuvers and stuck detection
module controle_aspirador #(
  parameter int TURN_CYCLES = 50000000,
  parameter int BACK_CYCLES = 25000000,
  parameter int STUCK_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LD,
  input  logic       E,
  input  logic       D,
  input  logic       F,
  input  logic       A,
  output logic       mot_frente,
  output logic       mot_re,
  output logic       gira_esq,
  output logic       gira_dir,
  output logic [2:0] codigo,
  output logic       Erro
);
  localparam int MAXC = TURN_CYCLES > BACK_CYCLES ? TURN_CYCLES : BACK_CYCLES;
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] BACK_LOAD = TW'(BACK_CYCLES - 1);
  localparam logic [2:0] OFF    = 3'b000;
  localparam logic [2:0] FRENTE = 3'b001;
  localparam logic [2:0] RE     = 3'b010;
  localparam logic [2:0] GIRA_E = 3'b011;
  localparam logic [2:0] GIRA_D = 3'b100;
  localparam logic [2:0] ERRO   = 3'b111;

  logic [4:0] sync1, sync2;
  logic ld_s, e_s, d_s, f_s, a_s;
  logic [2:0] state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [SW-1:0] stuck_cnt, stuck_n;
  logic stuck_hit;
  logic [2:0] back_state;
  logic [TW-1:0] back_timer;
  logic [SW-1:0] back_stuck;

  assign {ld_s, e_s, d_s, f_s, a_s} = sync2;
  // reverse entry: give up once another reverse would reach the stuck limit
  assign stuck_hit  = 32'(stuck_cnt) + 1 >= STUCK_LIMIT;
  assign back_state = stuck_hit ? ERRO : RE;
  assign back_timer = stuck_hit ? timer : BACK_LOAD;
  assign back_stuck = stuck_hit ? stuck_cnt : stuck_cnt + 1'b1;

  // two-flop synchronisers for the switch and all obstacle sensors
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {LD, E, D, F, A};
      sync2 <= sync1;
    end

  // next state, maneuver timer and stuck counter; power-off overrides everything
  always_comb begin
    state_n = state;
    timer_n = timer;
    stuck_n = stuck_cnt;
    if (!ld_s) begin
      state_n = OFF;
      timer_n = '0;
      stuck_n = '0;
    end else case (state)
      OFF: begin
        state_n = FRENTE;
        stuck_n = '0;
      end
      FRENTE:
        if (!f_s) stuck_n = '0;
        else if (!e_s) begin
          state_n = GIRA_E;
          timer_n = TURN_LOAD;
        end else if (!d_s) begin
          state_n = GIRA_D;
          timer_n = TURN_LOAD;
        end else if (!a_s) begin
          state_n = back_state;
          timer_n = back_timer;
          stuck_n = back_stuck;
        end else state_n = ERRO;
      RE:
        if (a_s || timer == '0) begin
          if (!e_s) begin
            state_n = GIRA_E;
            timer_n = TURN_LOAD;
          end else if (!d_s) begin
            state_n = GIRA_D;
            timer_n = TURN_LOAD;
          end else if (a_s) state_n = ERRO;
          else begin
            state_n = back_state;
            timer_n = back_timer;
            stuck_n = back_stuck;
          end
        end else timer_n = timer - 1'b1;
      GIRA_E, GIRA_D:
        if (timer == '0) state_n = FRENTE;
        else timer_n = timer - 1'b1;
      default: state_n = ERRO;
    endcase
  end

  // state register with outputs decoded from the next state so they are glitch-free flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= OFF;
      timer      <= '0;
      stuck_cnt  <= '0;
      mot_frente <= 1'b0;
      mot_re     <= 1'b0;
      gira_esq   <= 1'b0;
      gira_dir   <= 1'b0;
      codigo     <= OFF;
      Erro       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      stuck_cnt  <= stuck_n;
      mot_frente <= state_n == FRENTE;
      mot_re     <= state_n == RE;
      gira_esq   <= state_n == GIRA_E;
      gira_dir   <= state_n == GIRA_D;
      codigo     <= state_n;
      Erro       <= state_n == ERRO;
    end
endmodule

// File: tb/tb_controle_aspirador.sv
// tb_controle_aspirador: directed test-plan steps plus randomized sensors against a behavioural model
module tb_controle_aspirador;
  localparam int TC = 4, BC = 3, SL = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic LD = 1'b0, E = 1'b0, D = 1'b0, F = 1'b0, A = 1'b0;
  logic mot_frente, mot_re, gira_esq, gira_dir, Erro;
  logic [2:0] codigo;
  int checks = 0, errors = 0;
  int mode = 0, left = 0, stuck = 0;
  logic [4:0] s1 = '0, s2 = '0;

  controle_aspirador #(.TURN_CYCLES(TC), .BACK_CYCLES(BC), .STUCK_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .LD(LD), .E(E), .D(D), .F(F), .A(A),
    .mot_frente(mot_frente), .mot_re(mot_re), .gira_esq(gira_esq), .gira_dir(gira_dir),
    .codigo(codigo), .Erro(Erro)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic ld, e, d, f, a);
    {LD, E, D, F, A} = {ld, e, d, f, a};
  endtask

  task automatic turn(input int m);
    mode = m;
    left = TC;
  endtask

  task automatic reverse_entry();
    if (stuck + 1 >= SL) mode = 7;
    else begin
      mode = 2;
      left = BC;
      stuck = stuck + 1;
    end
  endtask

  task automatic model_reset();
    mode = 0;
    left = 0;
    stuck = 0;
    s1 = '0;
    s2 = '0;
  endtask

  task automatic model_tick();
    logic ld, e, d, f, a;
    {ld, e, d, f, a} = s2;
    if (!ld) begin
      mode = 0;
      left = 0;
      stuck = 0;
    end else if (mode == 0) begin
      mode = 1;
      stuck = 0;
    end else if (mode == 1) begin
      if (!f) stuck = 0;
      else if (!e) turn(3);
      else if (!d) turn(4);
      else if (!a) reverse_entry();
      else mode = 7;
    end else if (mode == 2) begin
      if (a || left == 1) begin
        if (!e) turn(3);
        else if (!d) turn(4);
        else if (a) mode = 7;
        else reverse_entry();
      end else left = left - 1;
    end else if (mode == 3 || mode == 4) begin
      if (left == 1) mode = 1;
      else left = left - 1;
    end
    s2 = s1;
    s1 = {LD, E, D, F, A};
  endtask

  task automatic check(input string tag);
    logic [7:0] obs, exp;
    obs = {mot_frente, mot_re, gira_esq, gira_dir, codigo, Erro};
    exp = {mode == 1, mode == 2, mode == 3, mode == 4, 3'(mode), mode == 7};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_code(input string tag, input logic [2:0] want);
    checks++;
    assert (codigo === want) else begin
      errors++;
      $error("FAIL %s codigo=%b expected=%b", tag, codigo, want);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_tick();
    #1;
    check(tag);
  endtask

  task automatic expect_seq(input string tag, input logic [2:0] want, input int n);
    for (int i = 0; i < n; i++) begin
      tick(tag);
      chk_code(tag, want);
    end
  endtask

  initial begin
    #1;
    check("reset_state");
    chk_code("reset_code", 3'b000);
    #1 reset = 1'b0;
    // power-on
    set_in(1, 0, 0, 0, 0);
    expect_seq("power_off_wait", 3'b000, 2);
    expect_seq("power_fwd", 3'b001, 3);
    // front obstacle, left free
    set_in(1, 0, 0, 1, 0);
    expect_seq("pre_turn_e", 3'b001, 2);
    expect_seq("turn_e", 3'b011, 1);
    set_in(1, 0, 0, 0, 0);
    expect_seq("turn_e", 3'b011, 3);
    expect_seq("turn_e_done", 3'b001, 1);
    // front obstacle, right free
    set_in(1, 1, 0, 1, 0);
    expect_seq("pre_turn_d", 3'b001, 2);
    expect_seq("turn_d", 3'b100, 1);
    set_in(1, 0, 0, 0, 0);
    expect_seq("turn_d", 3'b100, 3);
    expect_seq("turn_d_done", 3'b001, 1);
    // reverse then turn left
    set_in(1, 1, 1, 1, 0);
    expect_seq("pre_re", 3'b001, 2);
    expect_seq("re", 3'b010, 1);
    set_in(1, 0, 1, 0, 0);
    expect_seq("re", 3'b010, 2);
    expect_seq("re_turn_e", 3'b011, 4);
    expect_seq("re_turn_done", 3'b001, 1);
    // stuck: second reverse hits the limit
    set_in(1, 1, 1, 1, 0);
    expect_seq("pre_stuck", 3'b001, 2);
    expect_seq("stuck_re", 3'b010, 3);
    expect_seq("stuck_erro", 3'b111, 1);
    set_in(1, 0, 0, 0, 0);
    expect_seq("erro_sticky", 3'b111, 4);
    set_in(0, 0, 0, 0, 0);
    expect_seq("erro_ld_wait", 3'b111, 2);
    expect_seq("erro_to_off", 3'b000, 2);
    set_in(1, 0, 0, 0, 0);
    expect_seq("repower_wait", 3'b000, 2);
    expect_seq("repower_fwd", 3'b001, 1);
    // rear abort after a single RE cycle
    set_in(1, 1, 1, 1, 0);
    tick("abort_setup");
    set_in(1, 1, 0, 1, 1);
    tick("abort_setup");
    expect_seq("abort_re", 3'b010, 1);
    set_in(1, 0, 0, 0, 0);
    expect_seq("abort_gira_d", 3'b100, 4);
    expect_seq("abort_done", 3'b001, 1);
    // asynchronous reset mid-turn
    set_in(1, 0, 1, 1, 0);
    expect_seq("pre_rst_turn", 3'b001, 2);
    expect_seq("rst_turn", 3'b011, 1);
    set_in(1, 0, 0, 0, 0);
    expect_seq("rst_turn", 3'b011, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_reset");
    chk_code("async_reset_code", 3'b000);
    #1 reset = 1'b0;
    expect_seq("post_rst_wait", 3'b000, 2);
    expect_seq("post_rst_fwd", 3'b001, 1);
    // randomized sensors and power switch
    for (int n = 0; n < 3000; ) begin
      int hold;
      set_in($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) tick("random");
      n += hold;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controle_aspirador.md
# controle_aspirador

Moore state machine that sequences the robot vacuum's motion. It synchronises the four obstacle sensors and the power switch, and drives the forward, reverse and turn motor enables. It runs the timed reverse and turn maneuvers and detects a stuck condition. It also produces the 3-bit status code and `Erro` flag consumed by the 7-segment display decoder, so it sits between the sensor inputs and both the motor drivers and the display.

## Interface
Parameters:
- `TURN_CYCLES`, default 50000000: length of a turn maneuver in clocks (1 s at 50 MHz). Must be ≥1.
- `BACK_CYCLES`, default 25000000: length of a reverse maneuver in clocks. Must be ≥1.
- `STUCK_LIMIT`, default 3: consecutive reverse maneuvers without forward progress that force ERRO. Must be ≥1.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `LD` in 1: power switch, 1 = on.
- `E`, `D`, `F`, `A` in 1 each: obstacle sensors for left, right, front and rear. 1 = obstacle.
- `mot_frente` out 1: forward drive enable.
- `mot_re` out 1: reverse drive enable.
- `gira_esq` out 1: left turn enable.
- `gira_dir` out 1: right turn enable.
- `codigo` out 3: status code for the display.
- `Erro` out 1: error flag for the display.

## Operation
- Synchroniser:
  - Each of `LD`, `E`, `D`, `F`, `A` passes through a 2-flop synchroniser. The synchronised copies are `*_s`.
  - The FSM uses only the `*_s` signals.
- States and their `codigo`:
  - OFF = 000
  - FRENTE = 001
  - RE = 010
  - GIRA_E = 011
  - GIRA_D = 100
  - ERRO = 111
- Outputs per state; all outputs not listed are 0:
  - FRENTE: `mot_frente`=1.
  - RE: `mot_re`=1.
  - GIRA_E: `gira_esq`=1.
  - GIRA_D: `gira_dir`=1.
  - ERRO: `Erro`=1.
- Rule 0, highest priority: `LD_s`=0 sends any state, including ERRO, to OFF. Entering OFF clears the timer and `stuck_cnt`.
- OFF: `LD_s`=1 → FRENTE, with `stuck_cnt`=0.
- FRENTE:
  - While `F_s`=0, stay in FRENTE and clear `stuck_cnt` each cycle.
  - When `F_s`=1, the next state is the first match:
    - `E_s`=0 → GIRA_E.
    - `D_s`=0 → GIRA_D.
    - `A_s`=0 → reverse entry.
    - Otherwise → ERRO.
- Reverse entry:
  - If `stuck_cnt`+1 ≥ `STUCK_LIMIT`, go to ERRO.
  - Otherwise go to RE, increment `stuck_cnt` and load the timer with `BACK_CYCLES`-1.
- RE:
  - If `A_s`=1, abort the reverse. Go to GIRA_E if `E_s`=0, else GIRA_D if `D_s`=0, else ERRO.
  - Otherwise, when the timer reaches 0, go to GIRA_E if `E_s`=0, else GIRA_D if `D_s`=0, else take reverse entry again.
  - Otherwise decrement the timer.
- GIRA_E / GIRA_D:
  - Entry loads the timer with `TURN_CYCLES`-1. The turn then lasts exactly `TURN_CYCLES` clocks.
  - Sensors are ignored during a turn.
  - When the timer reaches 0, go to FRENTE.
- ERRO: sticky. The only exit is rule 0 or `reset`.
- Counter widths:
  - The timer is wide enough for max(`TURN_CYCLES`,`BACK_CYCLES`)-1.
  - `stuck_cnt` is wide enough for `STUCK_LIMIT` and saturates at that value; it must not wrap.

## Timing
- Reset: state OFF, all outputs 0 (`codigo`=000), timer 0, `stuck_cnt` 0, synchroniser flops 0.
- Outputs are registered together with the state register. They must be glitch-free, with no combinational path from any input.
- Latency: an input that is stable before rising edge k reaches `*_s` at edge k+1. The state and outputs change at edge k+2, i.e. 2 clocks.
- A maneuver state occupies exactly N cycles (`TURN_CYCLES` or `BACK_CYCLES`), measured from its first output cycle to the first cycle of the next state. An abort from RE due to `A_s` is the exception.
- Simultaneous events: rule 0 beats timer expiry, sensor changes and ERRO. A timer expiring in the same cycle as `A_s` rising in RE takes the abort path.
- Reset mid-maneuver: all outputs drop to 0 asynchronously. After release, the FSM restarts from OFF and needs `LD_s`=1 to move.
- Reset release must be synchronous to `clk` at the system level. The block itself does not synchronise the deassertion of `reset`.

## Test plan
Benches use `TURN_CYCLES`=4, `BACK_CYCLES`=3, `STUCK_LIMIT`=2.

1. Power-on: assert `reset`, release it, raise `LD`=1 with all sensors 0. Required: `codigo`=000 until 2 clocks after `LD`, then 001 with `mot_frente`=1 held steady.
2. Front obstacle with left free: `F`=1, `E`=0. Required: `codigo`=011 and `gira_esq`=1 for exactly 4 cycles, then 001. Repeat with `E`=1, `D`=0 and require `codigo`=100.
3. Reverse then turn:
   - Stimulus: `F`=`E`=`D`=1, `A`=0. Once RE is entered, drop `E` to 0.
   - Required: `codigo`=010 and `mot_re`=1 for 3 cycles, then 011 for 4 cycles, then 001.
4. Stuck:
   - Stimulus: `F`=`E`=`D`=1 held with `A`=0.
   - Required: RE for 3 cycles (`stuck_cnt`=1). Expiry with the sides still blocked hits the limit of 2, so the next state is `codigo`=111, `Erro`=1.
   - ERRO must persist with all sensors cleared. `LD`=0 must give 000 two clocks later.
5. Rear abort: enter RE, then set `A`=1 and `D`=0 on the next cycle. Required: leave RE before the timer expires, straight to GIRA_D (`codigo`=100).
6. Reset mid-turn: assert `reset` during GIRA_E. Required: all outputs 0 immediately, without waiting for a clock edge. After release with `LD`=1, `codigo`=001 follows 2 clocks later.
